// File: rtl/reg_mem_wb.sv
// reg_mem_wb: MEM/WB pipeline register with write-back select, retired-instruction counter and last-write bypass
module reg_mem_wb #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [9:0]        Control,
   input  logic [DATA_W-1:0] alu_res,
   input  logic [DATA_W-1:0] mem_data,
   input  logic [REG_W-1:0]  dest_reg,
   input  logic              valid_in,
   input  logic              stall,
   input  logic              flush,
   output logic              MemaReg,
   output logic              EscrReg,
   output logic [DATA_W-1:0] wb_data,
   output logic [REG_W-1:0]  wb_reg,
   output logic              wb_we,
   output logic              valid_out,
   output logic [DATA_W-1:0] fwd_data,
   output logic [REG_W-1:0]  fwd_reg,
   output logic              fwd_we,
   output logic [CNT_W-1:0]  retired
);
   logic [DATA_W-1:0] alu_q, mem_q;
   logic retire;
   logic unused_ctrl;
   assign unused_ctrl = ^{Control[9:7], Control[4:0]};
   assign wb_data = MemaReg ? mem_q : alu_q;
   assign wb_we = EscrReg & valid_out & (wb_reg != '0);
   // the occupant leaves on flush too: flush only kills the incoming instruction
   assign retire = valid_out & (flush | ~stall);
   always_ff @(posedge clk) begin
      if (!reset) begin
         MemaReg   <= 1'b0;
         EscrReg   <= 1'b0;
         valid_out <= 1'b0;
         wb_reg    <= '0;
         alu_q     <= '0;
         mem_q     <= '0;
         fwd_data  <= '0;
         fwd_reg   <= '0;
         fwd_we    <= 1'b0;
         retired   <= '0;
      end else begin
         if (flush) begin
            MemaReg   <= 1'b0;
            EscrReg   <= 1'b0;
            valid_out <= 1'b0;
            wb_reg    <= '0;
            alu_q     <= '0;
            mem_q     <= '0;
         end else if (!stall) begin
            MemaReg   <= Control[6];
            EscrReg   <= Control[5];
            valid_out <= valid_in;
            wb_reg    <= dest_reg;
            alu_q     <= alu_res;
            mem_q     <= mem_data;
         end
         if (retire) retired <= retired + 1'b1;
         if (retire && wb_we) begin
            fwd_data <= wb_data;
            fwd_reg  <= wb_reg;
            fwd_we   <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_reg_mem_wb.sv
// tb_reg_mem_wb: directed vectors with hand-computed expectations, queued and checked by a monitor
module tb_reg_mem_wb;
   typedef struct packed {
      logic        v, mr, er, we;
      logic [4:0]  r;
      logic [31:0] d;
      logic        fwe;
      logic [4:0]  fr;
      logic [31:0] fd;
      logic [3:0]  ret;
   } exp_t;
   logic clk = 1'b0, reset = 1'b0, valid_in = 1'b0, stall = 1'b0, flush = 1'b0;
   logic [9:0] Control = '0;
   logic [31:0] alu_res = '0, mem_data = '0;
   logic [4:0] dest_reg = '0;
   logic MemaReg, EscrReg, wb_we, valid_out, fwd_we;
   logic [31:0] wb_data, fwd_data;
   logic [4:0] wb_reg, fwd_reg;
   logic [3:0] retired;
   exp_t q[$];
   string nq[$];
   int checks = 0, failures = 0;
   reg_mem_wb #(.DATA_W(32), .REG_W(5), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .Control(Control), .alu_res(alu_res), .mem_data(mem_data),
      .dest_reg(dest_reg), .valid_in(valid_in), .stall(stall), .flush(flush),
      .MemaReg(MemaReg), .EscrReg(EscrReg), .wb_data(wb_data), .wb_reg(wb_reg), .wb_we(wb_we),
      .valid_out(valid_out), .fwd_data(fwd_data), .fwd_reg(fwd_reg), .fwd_we(fwd_we), .retired(retired)
   );
   always #5 clk = ~clk;
   function automatic exp_t mk(logic v, mr, er, we, logic [4:0] r, logic [31:0] d,
                               logic fwe, logic [4:0] fr, logic [31:0] fd, logic [3:0] ret);
      return '{v: v, mr: mr, er: er, we: we, r: r, d: d, fwe: fwe, fr: fr, fd: fd, ret: ret};
   endfunction
   task automatic cyc(input string n, input logic rs, st, fl, vi, input logic [9:0] c,
                      input logic [31:0] a, m, input logic [4:0] dr, input exp_t e);
      @(negedge clk);
      reset = rs; stall = st; flush = fl; valid_in = vi;
      Control = c; alu_res = a; mem_data = m; dest_reg = dr;
      q.push_back(e);
      nq.push_back(n);
   endtask
   initial begin
      exp_t e, act;
      string n;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            n = nq.pop_front();
            act = '{v: valid_out, mr: MemaReg, er: EscrReg, we: wb_we, r: wb_reg, d: wb_data,
                    fwe: fwd_we, fr: fwd_reg, fd: fwd_data, ret: retired};
            checks++;
            if (act !== e) begin
               failures++;
               $display("FAIL %s got v=%b mr=%b er=%b we=%b reg=%0d data=%h fwe=%b freg=%0d fdata=%h ret=%0d exp v=%b mr=%b er=%b we=%b reg=%0d data=%h fwe=%b freg=%0d fdata=%h ret=%0d",
                        n, act.v, act.mr, act.er, act.we, act.r, act.d, act.fwe, act.fr, act.fd, act.ret,
                        e.v, e.mr, e.er, e.we, e.r, e.d, e.fwe, e.fr, e.fd, e.ret);
            end
         end
      end
   end
   initial begin
      exp_t z, a7;
      z = mk(0,0,0,0,0,0,0,0,0,0);
      cyc("reset1", 0,0,0,1, 10'h3FF, 32'h1, 32'h2, 5'd1, z);
      cyc("reset2", 0,0,0,1, 10'h3FF, 32'h1, 32'h2, 5'd1, z);
      cyc("lw_sel", 1,0,0,1, 10'h060, 32'h10, 32'hDEADBEEF, 5'd8, mk(1,1,1,1,8,32'hDEADBEEF,0,0,0,0));
      cyc("r_sel",  1,0,0,1, 10'h020, 32'h10, 32'hDEADBEEF, 5'd8, mk(1,0,1,1,8,32'h10,1,8,32'hDEADBEEF,1));
      cyc("reg0",   1,0,0,1, 10'h060, 32'h20, 32'h30, 5'd0, mk(1,1,1,0,0,32'h30,1,8,32'h10,2));
      cyc("nowrite",1,0,0,1, 10'h000, 32'h40, 32'h50, 5'd3, mk(1,0,0,0,3,32'h40,1,8,32'h10,3));
      a7 = mk(1,0,1,1,4,32'h7,1,8,32'h10,4);
      cyc("load_a", 1,0,0,1, 10'h020, 32'h7, 32'h99, 5'd4, a7);
      cyc("stall1", 1,1,0,1, 10'h060, 32'h55, 32'h66, 5'd9, a7);
      cyc("stall2", 1,1,0,0, 10'h3FF, 32'h56, 32'h67, 5'd10, a7);
      cyc("stall3", 1,1,0,1, 10'h000, 32'h57, 32'h68, 5'd11, a7);
      cyc("unstall",1,0,0,1, 10'h020, 32'h11, 32'h0, 5'd5, mk(1,0,1,1,5,32'h11,1,4,32'h7,5));
      cyc("stl_fl", 1,1,1,1, 10'h060, 32'h1, 32'h2, 5'd6, mk(0,0,0,0,0,0,1,5,32'h11,6));
      cyc("bubble_occ",1,0,0,1, 10'h020, 32'h3, 32'h4, 5'd7, mk(1,0,1,1,7,32'h3,1,5,32'h11,6));
      cyc("mid_reset",0,1,1,1, 10'h020, 32'h3, 32'h4, 5'd7, z);
      for (int i = 0; i < 17; i++) begin
         logic [4:0] r;
         logic [3:0] ret;
         r = 5'(i + 1);
         ret = 4'(i);
         cyc($sformatf("wrap%0d", i), 1,0,0,1, 10'h020, 32'(100 + i), 32'hFFFF, r,
             mk(1,0,1,1,r,32'(100 + i),(i > 0),(i > 0) ? 5'(i) : 5'd0,(i > 0) ? 32'(99 + i) : 32'd0,ret));
      end
      cyc("drain", 1,0,0,0, 10'h000, 32'h0, 32'h0, 5'd0, mk(0,0,0,0,0,0,1,17,32'd116,1));
      for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
      if (q.size() > 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
